// File: rtl/imm_gen_pipe_if.sv
// Handshake and payload bundle between decode and execute for the immediate generator.
// slave is the generator's view; master is the upstream/downstream view.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            InValid;
  logic            InReady;
  logic [3:0]      ImmSrc;
  logic [24:0]     InstrImm;
  logic [XLEN-1:0] PCIn;
  logic            OutValid;
  logic            OutReady;
  logic [XLEN-1:0] ExtImm;
  logic [XLEN-1:0] Target;
  logic            IllegalImm;

  modport master (
    output InValid, ImmSrc, InstrImm, PCIn, OutReady,
    input  InReady, OutValid, ExtImm, Target, IllegalImm
  );

  modport slave (
    input  InValid, ImmSrc, InstrImm, PCIn, OutReady,
    output InReady, OutValid, ExtImm, Target, IllegalImm
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with optional PC-relative target adder.
// Main register drives the outputs; a one-entry skid register absorbs back-pressure.
module imm_gen_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter bit          TARGET_EN = 1'b1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Flush,
  imm_gen_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FmtR   = 3'b000,
    FmtI   = 3'b001,
    FmtS   = 3'b010,
    FmtB   = 3'b011,
    FmtU   = 3'b100,
    FmtJ   = 3'b101,
    FmtZ   = 3'b110,
    FmtBad = 3'b111
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } entry_t;

  fmt_e            fmt;
  logic            sign;
  logic [XLEN-1:0] ext_imm;
  logic            ill;
  entry_t          in_entry;

  entry_t m_q, m_d, k_q, k_d;
  logic   m_valid_q, m_valid_d;
  logic   k_valid_q, k_valid_d;
  logic   in_fire, out_fire;

  // Immediate decode. Field selects are instruction bit numbers minus 7.
  always_comb begin
    fmt     = fmt_e'(bus.ImmSrc[2:0]);
    // Unsigned modifier only affects I and B.
    sign    = bus.InstrImm[24] & ~(bus.ImmSrc[3] & ((fmt == FmtI) || (fmt == FmtB)));
    ext_imm = {XLEN{sign}};
    ill     = 1'b0;
    unique case (fmt)
      FmtR: ext_imm = '0;
      FmtI: ext_imm[11:0] = bus.InstrImm[24:13];
      FmtS: ext_imm[11:0] = {bus.InstrImm[24:18], bus.InstrImm[4:0]};
      FmtB: ext_imm[12:0] = {bus.InstrImm[24], bus.InstrImm[0], bus.InstrImm[23:18],
                             bus.InstrImm[4:1], 1'b0};
      FmtU: ext_imm[31:0] = {bus.InstrImm[24:5], 12'h000};
      FmtJ: ext_imm[20:0] = {bus.InstrImm[24], bus.InstrImm[12:5], bus.InstrImm[13],
                             bus.InstrImm[23:14], 1'b0};
      FmtZ: begin
        ext_imm      = '0;
        ext_imm[4:0] = bus.InstrImm[12:8];
      end
      FmtBad: begin
        ext_imm = '0;
        ill     = 1'b1;
      end
      default: ext_imm = '0;
    endcase

    in_entry.imm = ext_imm;
    in_entry.tgt = TARGET_EN ? (bus.PCIn + ext_imm) : '0;
    in_entry.ill = ill;
  end

  // Skid-buffer control. Flush wins over every transfer.
  always_comb begin
    in_fire   = bus.InValid & ~k_valid_q;
    out_fire  = m_valid_q & bus.OutReady;
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;

    if (Flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (k_valid_q) begin
      // InReady is low, so no input can arrive while K drains.
      if (out_fire) begin
        m_d       = k_q;
        m_valid_d = 1'b1;
        k_valid_d = 1'b0;
      end
    end else if (!m_valid_q || out_fire) begin
      m_valid_d = in_fire;
      if (in_fire) begin
        m_d = in_entry;
      end
    end else if (in_fire) begin
      k_d       = in_entry;
      k_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
    end
  end

  assign bus.InReady    = ~k_valid_q;
  assign bus.OutValid   = m_valid_q;
  assign bus.ExtImm     = m_q.imm;
  assign bus.Target     = m_q.tgt;
  assign bus.IllegalImm = m_q.ill;

endmodule
